// File: rtl/serial_sub_unit_pkg.sv
// Shared types for the digit-serial subtractor: FSM states and operating modes.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } sub_state_t;

    typedef enum logic {
        MODE_MAG  = 1'b0,
        MODE_TWOS = 1'b1
    } sub_mode_t;

endpackage

// File: rtl/serial_sub_unit_digit.sv
// One DIGIT-wide borrow-propagating subtract slice: d = x - y - bin, bout = borrow out.
module sub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    // One guard bit: a negative slice result shows up as a set top bit.
    logic [DIGIT:0] full;

    assign full = {1'b0, x} - {1'b0, y} - (DIGIT+1)'(bin);
    assign d    = full[DIGIT-1:0];
    assign bout = full[DIGIT];

endmodule

// File: rtl/serial_sub_unit.sv
// Digit-serial A-B with magnitude or two's-complement result and NZCV-style flags.
// Fixed latency STEPS+1 edges from accept to out_valid; holds result in DONE until out_ready.
module serial_sub_unit
    import sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             neg,
    output logic             zero,
    output logic             carry,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_sub_unit: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    sub_state_t       state_q;
    sub_mode_t        mode_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic [WIDTH-1:0] result_q;
    logic             neg_q;
    logic             zero_q;
    logic             carry_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [DIGIT-1:0] dig_d;
    logic             bout_d;
    logic [WIDTH-1:0] diff_d;
    logic [WIDTH-1:0] res_fix_d;
    logic             neg_fix_d;
    logic             ovf_fix_d;

    sub_digit #(.DIGIT(DIGIT)) u_digit (
        .x    (a_q[DIGIT-1:0]),
        .y    (b_q[DIGIT-1:0]),
        .bin  (borrow_q),
        .d    (dig_d),
        .bout (bout_d)
    );

    // Difference digits enter at the top so the LSB digit lands at bit 0 after STEPS shifts.
    assign diff_d = (diff_q >> DIGIT) | (WIDTH'(dig_d) << (WIDTH - DIGIT));

    always_comb begin
        res_fix_d = diff_q;
        neg_fix_d = diff_q[WIDTH-1];
        ovf_fix_d = 1'b0;
        if (mode_q == MODE_MAG) begin
            neg_fix_d = borrow_q;
            if (borrow_q) begin
                res_fix_d = WIDTH'(0) - diff_q;
            end
        end else begin
            ovf_fix_d = (a_msb_q != b_msb_q) && (diff_q[WIDTH-1] != a_msb_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= MODE_MAG;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            cnt_q       <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            result_q    <= '0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        mode_q     <= sub_mode_t'(mode);
                        a_msb_q    <= a[WIDTH-1];
                        b_msb_q    <= b[WIDTH-1];
                        diff_q     <= '0;
                        borrow_q   <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    a_q      <= a_q >> DIGIT;
                    b_q      <= b_q >> DIGIT;
                    diff_q   <= diff_d;
                    borrow_q <= bout_d;
                    if (cnt_q == CW'(STEPS - 1)) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                FIX: begin
                    result_q    <= res_fix_d;
                    neg_q       <= neg_fix_d;
                    ovf_q       <= ovf_fix_d;
                    zero_q      <= (res_fix_d == '0);
                    carry_q     <= ~borrow_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign neg       = neg_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_sub_unit.sv
// Directed and randomized checks of serial_sub_unit at (8,2), (8,8) and (16,4) sharing one stimulus.
module tb_serial_sub_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_s;
    logic        out_ready_s;
    logic [15:0] a_s;
    logic [15:0] b_s;
    logic        mode_s;

    logic [2:0]  in_rdy;
    logic [2:0]  out_vld;
    logic [2:0]  neg_w;
    logic [2:0]  zero_w;
    logic [2:0]  carry_w;
    logic [2:0]  ovf_w;
    logic [7:0]  res0;
    logic [7:0]  res1;
    logic [15:0] res2;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat [3];
    logic [19:0] obs [3];

    always #5 clk = ~clk;

    serial_sub_unit #(.WIDTH(8), .DIGIT(2)) dut_8_2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_rdy[0]),
        .a(a_s[7:0]), .b(b_s[7:0]), .mode(mode_s), .out_valid(out_vld[0]),
        .out_ready(out_ready_s), .result(res0), .neg(neg_w[0]), .zero(zero_w[0]),
        .carry(carry_w[0]), .ovf(ovf_w[0])
    );

    serial_sub_unit #(.WIDTH(8), .DIGIT(8)) dut_8_8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_rdy[1]),
        .a(a_s[7:0]), .b(b_s[7:0]), .mode(mode_s), .out_valid(out_vld[1]),
        .out_ready(out_ready_s), .result(res1), .neg(neg_w[1]), .zero(zero_w[1]),
        .carry(carry_w[1]), .ovf(ovf_w[1])
    );

    serial_sub_unit #(.WIDTH(16), .DIGIT(4)) dut_16_4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_rdy[2]),
        .a(a_s), .b(b_s), .mode(mode_s), .out_valid(out_vld[2]),
        .out_ready(out_ready_s), .result(res2), .neg(neg_w[2]), .zero(zero_w[2]),
        .carry(carry_w[2]), .ovf(ovf_w[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Packed view {result, neg, zero, carry, ovf} of one DUT.
    function automatic logic [19:0] get_out(input int d);
        logic [15:0] r;
        case (d)
            0:       r = {8'h00, res0};
            1:       r = {8'h00, res1};
            default: r = res2;
        endcase
        return {r, neg_w[d], zero_w[d], carry_w[d], ovf_w[d]};
    endfunction

    // Whole-word arithmetic reference, independent of the digit-serial structure.
    function automatic logic [19:0] model(input int w, input logic [15:0] av,
                                          input logic [15:0] bv, input logic m);
        int mask = (1 << w) - 1;
        int ai = int'(av) & mask;
        int bi = int'(bv) & mask;
        int diff = (ai - bi) & mask;
        int res;
        logic n, z, c, v;
        c = (ai >= bi);
        if (!m) begin
            res = c ? diff : (bi - ai);
            n   = ~c;
            v   = 1'b0;
        end else begin
            res = diff;
            n   = ((diff >> (w - 1)) & 1) != 0;
            v   = (((ai >> (w - 1)) & 1) != ((bi >> (w - 1)) & 1)) &&
                  (((diff >> (w - 1)) & 1) != ((ai >> (w - 1)) & 1));
        end
        z = (res == 0);
        return {res[15:0], n, z, c, v};
    endfunction

    // Issue one op to all three units, record first out_valid cycle and outputs,
    // optionally stall dut_8_2 in DONE for 'hold' cycles, then release all.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic m, input int hold);
        for (int i = 0; i < 20 && in_rdy != 3'b111; i++) begin
            @(posedge clk); #1;
        end
        chk("idle_rdy", 32'(in_rdy), 32'h7);
        a_s = av; b_s = bv; mode_s = m;
        in_valid_s = 1'b1; out_ready_s = 1'b0;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        for (int d = 0; d < 3; d++) begin
            lat[d] = 0;
            obs[d] = '0;
        end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                if (out_vld[d] && lat[d] == 0) begin
                    lat[d] = k;
                    obs[d] = get_out(d);
                end
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_vld", 32'(out_vld[0]), 32'h1);
            chk("hold_dat", 32'(get_out(0)), 32'(obs[0]));
            chk("hold_rdy", 32'(in_rdy[0]), 32'h0);
        end
        out_ready_s = 1'b1;
        @(posedge clk); #1;
        out_ready_s = 1'b0;
        chk("ret_vld", 32'(out_vld), 32'h0);
        chk("ret_rdy", 32'(in_rdy), 32'h7);
    endtask

    initial begin
        logic [15:0] ra, rb;
        rst = 1'b1; in_valid_s = 1'b0; out_ready_s = 1'b0;
        a_s = '0; b_s = '0; mode_s = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_rdy", 32'(in_rdy), 32'h7);
        chk("rst_vld", 32'(out_vld), 32'h0);
        chk("rst_out0", 32'(get_out(0)), 32'h0);
        chk("rst_out2", 32'(get_out(2)), 32'h0);

        // Outputs {result, neg, zero, carry, ovf}, hand-computed for WIDTH=8.
        run_op(16'h0009, 16'h0003, 1'b0, 0);
        chk("mag_pos_lat", 32'(lat[0]), 32'd5);
        chk("mag_pos", 32'(obs[0]), {12'h0, 16'h0006, 4'b0010});

        run_op(16'h0003, 16'h0009, 1'b0, 0);
        chk("mag_neg", 32'(obs[0]), {12'h0, 16'h0006, 4'b1000});

        run_op(16'h0055, 16'h0055, 1'b0, 0);
        chk("mag_eq", 32'(obs[0]), {12'h0, 16'h0000, 4'b0110});

        run_op(16'h0055, 16'h0055, 1'b1, 0);
        chk("twos_eq", 32'(obs[0]), {12'h0, 16'h0000, 4'b0110});

        run_op(16'h0080, 16'h0001, 1'b1, 0);
        chk("twos_ovf", 32'(obs[0]), {12'h0, 16'h007F, 4'b0011});

        run_op(16'h0000, 16'h0001, 1'b1, 0);
        chk("twos_neg", 32'(obs[0]), {12'h0, 16'h00FF, 4'b1000});

        run_op(16'h00FF, 16'h0000, 1'b0, 4);
        chk("bp_res", 32'(obs[0]), {12'h0, 16'h00FF, 4'b0010});

        // Abort on the second CALC cycle.
        a_s = 16'h00F0; b_s = 16'h000F; mode_s = 1'b0; in_valid_s = 1'b1;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_rdy", 32'(in_rdy), 32'h7);
        chk("abort_vld", 32'(out_vld), 32'h0);
        chk("abort_out", 32'(get_out(0)), 32'h0);
        run_op(16'h0010, 16'h0001, 1'b0, 0);
        chk("after_abort", 32'(obs[0]), {12'h0, 16'h000F, 4'b0010});

        for (int m = 0; m < 2; m++) begin
            for (int n = 0; n < 1000; n++) begin
                ra = 16'($urandom);
                rb = (n % 50 == 0) ? ra : 16'($urandom);
                run_op(ra, rb, m[0], 0);
                chk("sw_lat_8_2", 32'(lat[0]), 32'd5);
                chk("sw_lat_8_8", 32'(lat[1]), 32'd2);
                chk("sw_lat_16_4", 32'(lat[2]), 32'd5);
                chk("sw_8_2", 32'(obs[0]), 32'(model(8, ra, rb, m[0])));
                chk("sw_8_8", 32'(obs[1]), 32'(model(8, ra, rb, m[0])));
                chk("sw_16_4", 32'(obs[2]), 32'(model(16, ra, rb, m[0])));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
